// File: rtl/handshake_fork_oehb_if.sv
// Handshake bundle for handshake_fork_oehb: one upstream producer channel and
// SIZE downstream consumer channels sharing a packed data bus.
interface handshake_fork_oehb_if #(
    parameter int DATA_TYPE = 32,
    parameter int SIZE      = 2
);
    logic [DATA_TYPE-1:0]      ins;
    logic                      ins_valid;
    logic                      ins_ready;
    logic [SIZE*DATA_TYPE-1:0] outs;
    logic [SIZE-1:0]           outs_valid;
    logic [SIZE-1:0]           outs_ready;

    // Environment side: drives the producer token and the consumer readies.
    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid
    );

    // Block side: accepts the producer token and offers copies downstream.
    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid
    );
endinterface

// File: rtl/handshake_fork_oehb.sv
// One-slot output-registered buffer feeding an eager fork: each consumer takes
// its copy independently, and the slot refills once every consumer is served.
module handshake_fork_oehb #(
    parameter int DATA_TYPE = 32,
    parameter int SIZE      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    handshake_fork_oehb_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [DATA_TYPE-1:0] data_reg;
    logic [SIZE-1:0]      sent, sent_next;
    logic [SIZE-1:0]      outs_valid, out_xfer;
    logic                 full, done, ins_ready, in_xfer;

    assign full       = (state == HOLD);
    assign outs_valid = {SIZE{full}} & ~sent;
    assign out_xfer   = outs_valid & bus.outs_ready;
    // Every copy is either already delivered or being taken right now.
    assign done       = full & (&(sent | bus.outs_ready));
    assign ins_ready  = ~full | done;
    assign in_xfer    = bus.ins_valid & ins_ready;

    assign bus.outs_valid = outs_valid;
    assign bus.ins_ready  = ins_ready;
    assign bus.outs       = {SIZE{data_reg}};

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_next = state;
        sent_next  = sent;
        case (state)
            EMPTY:   if (in_xfer) state_next = HOLD;
            HOLD:    if (done && !in_xfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (done) sent_next = '0;
        else      sent_next = sent | out_xfer;
    end

    // NOTE: data_reg is reset as well so outs reads zero while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments for all sequential state.
            state    <= EMPTY;
            sent     <= '0;
            data_reg <= '0;
        end else begin
            state <= state_next;
            sent  <= sent_next;
            if (in_xfer) data_reg <= bus.ins;
        end
    end
endmodule

// File: tb/tb_handshake_fork_oehb.sv
// Randomized and directed bench for handshake_fork_oehb against a token-level
// model (one slot plus per-output owed copies) and per-output scoreboards.
module tb_handshake_fork_oehb;
    localparam int W = 32;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    handshake_fork_oehb_if #(.DATA_TYPE(W), .SIZE(N)) bus_if ();

    handshake_fork_oehb #(.DATA_TYPE(W), .SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Token-level model: the token held for delivery and who still owes it.
    logic [W-1:0] accepted[$];
    int           got[N];
    bit           slot_full;
    logic [W-1:0] slot_data;
    logic [N-1:0] owe;

    // Pre-edge snapshot of the DUT for the cycle just executed.
    logic [N-1:0] s_ov;
    logic         s_rdy;
    logic [W-1:0] s_out[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot_full = 1'b0;
        slot_data = '0;
        owe       = '0;
        accepted.delete();
        for (int i = 0; i < N; i++) got[i] = 0;
    endtask

    // Drive one cycle, compare against the model before the edge, then advance.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic [N-1:0] r);
        logic [N-1:0] exp_ov;
        logic         exp_rdy;
        @(negedge clk);
        bus_if.ins_valid  = v;
        bus_if.ins        = d;
        bus_if.outs_ready = r;
        #1;
        s_ov  = bus_if.outs_valid;
        s_rdy = bus_if.ins_ready;
        for (int i = 0; i < N; i++) s_out[i] = bus_if.outs[i*W +: W];

        exp_ov  = slot_full ? owe : '0;
        exp_rdy = !slot_full || ((owe & ~r) == '0);
        check("outs_valid", s_ov, exp_ov);
        check("ins_ready", s_rdy, exp_rdy);
        for (int i = 0; i < N; i++)
            if (exp_ov[i]) check("outs_data", s_out[i], slot_data);

        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (s_ov[i] && r[i]) begin
                if (got[i] < accepted.size()) begin
                    check("scoreboard", s_out[i], accepted[got[i]]);
                end else begin
                    total++;
                    bad++;
                    $display("FAIL extra_token: output %0d delivered %0h with nothing owed", i, s_out[i]);
                end
                got[i]++;
            end
            if (exp_ov[i] && r[i]) owe[i] = 1'b0;
        end
        if (v && exp_rdy) begin
            accepted.push_back(d);
            slot_full = 1'b1;
            slot_data = d;
            owe       = '1;
        end else if (owe == '0) begin
            slot_full = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] rr;
        bus_if.ins_valid  = 1'b0;
        bus_if.ins        = '0;
        bus_if.outs_ready = '0;
        model_reset();
        #1;
        check("reset_outs_valid", bus_if.outs_valid, 2'b00);
        check("reset_ins_ready", bus_if.ins_ready, 1'b1);
        check("reset_outs", bus_if.outs, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Streaming at full rate.
        cycle(1'b1, 32'h1, 2'b11);
        check("stream0_rdy", s_rdy, 1'b1);
        check("stream0_ov", s_ov, 2'b00);
        cycle(1'b1, 32'h2, 2'b11);
        check("stream1_ov", s_ov, 2'b11);
        check("stream1_d0", s_out[0], 32'h1);
        check("stream1_d1", s_out[1], 32'h1);
        check("stream1_rdy", s_rdy, 1'b1);
        cycle(1'b1, 32'h3, 2'b11);
        check("stream2_d0", s_out[0], 32'h2);
        check("stream2_rdy", s_rdy, 1'b1);
        cycle(1'b0, 32'h0, 2'b11);
        check("stream3_d1", s_out[1], 32'h3);
        cycle(1'b0, 32'h0, 2'b11);
        check("stream4_ov", s_ov, 2'b00);

        // Skewed consumers.
        cycle(1'b1, 32'hA5A5_A5A5, 2'b01);
        cycle(1'b0, 32'h0, 2'b01);
        check("skew0_ov", s_ov, 2'b11);
        check("skew0_rdy", s_rdy, 1'b0);
        cycle(1'b0, 32'h0, 2'b01);
        check("skew1_ov", s_ov, 2'b10);
        check("skew1_rdy", s_rdy, 1'b0);
        cycle(1'b0, 32'h0, 2'b01);
        check("skew2_rdy", s_rdy, 1'b0);
        cycle(1'b0, 32'h0, 2'b10);
        check("skew3_ov", s_ov, 2'b10);
        check("skew3_d1", s_out[1], 32'hA5A5_A5A5);
        check("skew3_rdy", s_rdy, 1'b1);
        cycle(1'b0, 32'h0, 2'b00);
        check("skew4_ov", s_ov, 2'b00);

        // Backpressure: the held value must not follow the changing input.
        cycle(1'b1, 32'h100, 2'b00);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 32'h100 + k, 2'b00);
            check("bp_ov", s_ov, 2'b11);
            check("bp_data", s_out[0], 32'h100);
            check("bp_rdy", s_rdy, 1'b0);
        end
        cycle(1'b0, 32'h0, 2'b11);
        check("bp_drain_rdy", s_rdy, 1'b1);

        // Simultaneous refill as the last pending output accepts.
        cycle(1'b1, 32'h6, 2'b01);
        cycle(1'b0, 32'h0, 2'b01);
        cycle(1'b1, 32'h7, 2'b10);
        check("refill_pre_ov", s_ov, 2'b10);
        check("refill_pre_rdy", s_rdy, 1'b1);
        cycle(1'b0, 32'h0, 2'b00);
        check("refill_ov", s_ov, 2'b11);
        check("refill_d0", s_out[0], 32'h7);
        check("refill_d1", s_out[1], 32'h7);
        cycle(1'b0, 32'h0, 2'b11);

        // Asynchronous reset while holding a token offered on both outputs.
        cycle(1'b1, 32'h55, 2'b00);
        @(negedge clk);
        bus_if.ins_valid  = 1'b0;
        bus_if.outs_ready = 2'b00;
        #1;
        check("pre_reset_ov", bus_if.outs_valid, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        check("mid_reset_ov", bus_if.outs_valid, 2'b00);
        check("mid_reset_rdy", bus_if.ins_ready, 1'b1);
        check("mid_reset_outs", bus_if.outs, 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 2'b11);
            check("post_reset_ov", s_ov, 2'b00);
        end

        // Random traffic.
        for (int k = 0; k < 10000; k++) begin
            for (int i = 0; i < N; i++) rr[i] = ($urandom_range(0, 3) != 0);
            cycle(1'($urandom_range(0, 1)), W'($urandom), rr);
        end
        repeat (3) cycle(1'b0, 32'h0, '1);
        for (int i = 0; i < N; i++) check("delivered_count", got[i], accepted.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/handshake_fork_oehb.md
# handshake_fork_oehb

Elastic transmitter that takes one token from a single handshake channel and delivers a copy to SIZE downstream consumers, such as comparator or arithmetic operand ports. It sits upstream of join-based consumers and provides the producer side of their valid/ready protocol. It combines a one-slot output-registered buffer with an eager fork, so:
- valid and data to consumers are registered;
- each consumer may accept its copy in a different cycle without stalling the others.

## Interface
- DATA_TYPE, default 32: token data width in bits.
- SIZE, default 2: number of output channels, at least 1.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ins  input  DATA_TYPE  input token data.
- ins_valid  input  1  input token offered.
- ins_ready  output  1  block accepts the input token this cycle.
- outs  output  SIZE*DATA_TYPE  output data; slice i is bits [i*DATA_TYPE +: DATA_TYPE].
- outs_valid  output  SIZE  per-output token offered.
- outs_ready  input  SIZE  per-output consumer accepts.

## Operation
State:
- full: slot occupied.
- data_reg: DATA_TYPE bits.
- sent[SIZE]: per-output "copy already delivered" flags.

FSM: EMPTY (full=0) and HOLD (full=1).

Combinational outputs:
- outs slice i = data_reg for every i.
- outs_valid[i] = full & ~sent[i].
- done = full & AND over i of (sent[i] | outs_ready[i]).
- ins_ready = ~full | done.

Transfer events:
- Input transfer: ins_valid & ins_ready.
- Output transfer on channel i: outs_valid[i] & outs_ready[i].

Register updates:
- data_reg loads ins on an input transfer; otherwise it holds.
- full next: 1 if input transfer; else 0 if done; else it holds.
- sent[i] next: 0 if done; else 1 if output transfer i; else it holds.

FSM transitions:
- EMPTY to HOLD on an input transfer.
- HOLD to EMPTY on done without an input transfer.
- HOLD to HOLD on done with an input transfer. This back-to-back refill sustains 1 token/cycle.

Rules:
- Each token is delivered exactly once to every output. There is no duplication and no loss.
- Outputs are independent. A stalled output never blocks delivery to a ready output.
- A valid output never retracts, and its data never changes until the handshake completes on that channel or all outputs are done.
- ins is sampled only on an input transfer.

## Timing
- Reset (rst low, asynchronous) forces:
  - full=0, sent=0, data_reg=0;
  - outs_valid=0, outs=0;
  - ins_ready=1 as a combinational consequence of full=0.
- Reset asserted mid-operation discards the held token and all sent flags immediately. Outputs must not glitch valid high afterwards.
- Latency is 1 cycle: a token accepted at edge N has outs_valid high in cycle N+1.
- Throughput is 1 token/cycle when all outs_ready are held high.
- Paths from ins/ins_valid to outs/outs_valid are fully registered.
- The only combinational path is outs_ready to ins_ready, by design.
- If the last pending output accepts in the same cycle a new input arrives, both transfers occur. The new token appears next cycle with all sent flags cleared.
- SIZE=1 degenerates to a plain one-slot buffer and must still pass all checks.

## Test plan
- Reset: drive rst low mid-HOLD with outs_valid=2'b11 -> outs_valid=0 and ins_ready=1 immediately. After release, no output handshake happens until a new input transfer.
- Streaming: SIZE=2, outs_ready=2'b11, inputs 0x1, 0x2, 0x3 on consecutive cycles -> each output sees 0x1, 0x2, 0x3 on consecutive cycles, 1-cycle latency, ins_ready constantly 1.
- Skewed consumers: input 0xA5A5A5A5 with outs_ready=2'b01 for 3 cycles, then 2'b10:
  - output0 handshakes once in the first cycle, and outs_valid[0] is 0 afterwards;
  - ins_ready stays 0 until output1 handshakes;
  - the slot empties the cycle after output1 accepts.
- Backpressure: outs_ready=0 for 5 cycles with ins_valid high and data changing each cycle -> outs holds the first accepted value, and ins_ready stays 0 throughout.
- Simultaneous refill: HOLD with sent=2'b01, output1 accepts while ins_valid=1 carries 0x7 -> next cycle outs_valid=2'b11, data 0x7.
- Random: random ins_valid and outs_ready over 10k cycles, scoreboard per output -> the sequence on every output equals the accepted input sequence exactly.
